// File: rtl/hidden_spike_arbiter.sv
// Round-robin address-event arbiter from the hidden layer to the output layer.
// Grants sticky neuron requests with a one-cycle ack and queues addresses in a small FWFT FIFO.
module hidden_spike_arbiter #(
    parameter int unsigned N_NEURONS  = 16,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned ADDR_BASE  = 0,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_NEURONS-1:0] req_in,
    output logic [N_NEURONS-1:0] ack_out,
    input  logic                 out_ready,
    output logic                 out_spike,
    output logic [ADDR_W-1:0]    out_addr,
    output logic [CNT_W-1:0]     fifo_count,
    output logic [15:0]          event_count
);

    typedef enum logic [0:0] {StIdle, StAck} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  winner;
    logic              found;
    logic [IDX_W:0]    scan_idx;
    logic              grant;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;

    logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;

    // First requester at or above rr_ptr, wrapping modulo N_NEURONS.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < int'(N_NEURONS); i++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (scan_idx >= (IDX_W+1)'(N_NEURONS)) begin
                scan_idx = scan_idx - (IDX_W+1)'(N_NEURONS);
            end
            if (!found && req_in[scan_idx[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[IDX_W-1:0];
            end
        end
    end

    assign grant     = (state_q == StIdle) && found && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign pop       = out_spike && out_ready;
    assign push_addr = ADDR_W'(ADDR_BASE + 32'(winner));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            ack_out     <= '0;
            rr_ptr_q    <= '0;
            event_count <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant) begin
                        ack_out  <= N_NEURONS'(1) << winner;
                        rr_ptr_q <= (winner == IDX_W'(N_NEURONS - 1)) ? '0 : winner + 1'b1;
                        if (event_count != 16'hFFFF) begin
                            event_count <= event_count + 16'd1;
                        end
                        state_q  <= StAck;
                    end
                end
                StAck: begin
                    ack_out <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    ack_out <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            mem_q[wr_ptr_q] <= push_addr;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_count <= '0;
        end else begin
            if (grant) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({grant, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage is not reset, so the head is masked while the queue is empty.
    assign out_spike = (fifo_count != '0);
    assign out_addr  = out_spike ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_hidden_spike_arbiter.sv
// Directed bench for hidden_spike_arbiter: single grant, round-robin, backpressure,
// re-spike, asynchronous reset mid-ack and event counter saturation.
module tb_hidden_spike_arbiter;

    logic        clk;
    logic        resetn;
    logic [15:0] req_in;
    logic [15:0] ack_out;
    logic        out_ready;
    logic        out_spike;
    logic [7:0]  out_addr;
    logic [2:0]  fifo_count;
    logic [15:0] event_count;

    int   n_checks = 0;
    int   n_errors = 0;
    logic auto_clr = 1'b1;

    logic [15:0] rr_exp_a [6] = '{16'h0001, 16'h0000, 16'h0008, 16'h0000, 16'h8000, 16'h0000};
    logic [15:0] rr_exp_b [6] = '{16'h8000, 16'h0000, 16'h0001, 16'h0000, 16'h0008, 16'h0000};

    hidden_spike_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_in      (req_in),
        .ack_out     (ack_out),
        .out_ready   (out_ready),
        .out_spike   (out_spike),
        .out_addr    (out_addr),
        .fifo_count  (fifo_count),
        .event_count (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; neurons drop their request once acknowledged.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_clr) req_in = req_in & ~ack_out;
    endtask

    task automatic apply_reset();
        resetn    = 1'b0;
        req_in    = '0;
        out_ready = 1'b0;
        auto_clr  = 1'b1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        resetn    = 1'b0;
        req_in    = '0;
        out_ready = 1'b0;
        #12;
        check("rst_ack", ack_out, 0);
        check("rst_spike", out_spike, 0);
        check("rst_addr", out_addr, 0);
        check("rst_count", fifo_count, 0);
        check("rst_events", event_count, 0);
        apply_reset();

        // Single request
        out_ready = 1'b1;
        req_in    = 16'h0020;
        step();
        check("single_ack", ack_out, 16'h0020);
        check("single_spike", out_spike, 1);
        check("single_addr", out_addr, 5);
        check("single_events", event_count, 1);
        step();
        check("single_ack_off", ack_out, 0);
        check("single_spike_off", out_spike, 0);
        check("single_req_cleared", req_in, 0);

        // Round-robin from rr_ptr = 0
        apply_reset();
        out_ready = 1'b1;
        req_in    = 16'h8009;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_a_ack", ack_out, rr_exp_a[i]);
            if (i == 4) check("rr_a_addr15", out_addr, 15);
        end
        // Move rr_ptr to 4 by granting neuron 3 alone
        req_in = 16'h0008;
        step();
        check("rr_ptr_setup", ack_out, 16'h0008);
        step();
        req_in = 16'h8009;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_b_ack", ack_out, rr_exp_b[i]);
        end

        // Backpressure
        apply_reset();
        req_in = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_ack", ack_out, 16'h0001 << i);
            step();
        end
        check("bp_full", fifo_count, 4);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_no_ack", ack_out, 0);
        end
        check("bp_hold", fifo_count, 4);
        check("bp_head0", out_addr, 0);
        out_ready = 1'b1;
        step();
        check("bp_drain_ack", ack_out, 0);
        check("bp_head1", out_addr, 1);
        check("bp_cnt3", fifo_count, 3);
        step();
        check("bp_resume4", ack_out, 16'h0010);
        check("bp_head2", out_addr, 2);
        step();
        check("bp_head3", out_addr, 3);
        check("bp_cnt2", fifo_count, 2);
        step();
        check("bp_resume5", ack_out, 16'h0020);
        check("bp_head4", out_addr, 4);

        // Re-spike during ack
        apply_reset();
        auto_clr = 1'b0;
        req_in   = 16'h0080;
        step();
        check("rs_ack1", ack_out, 16'h0080);
        step();
        check("rs_gap", ack_out, 0);
        step();
        check("rs_ack2", ack_out, 16'h0080);
        check("rs_cnt", fifo_count, 2);
        check("rs_events", event_count, 2);
        req_in    = '0;
        out_ready = 1'b1;
        step();
        check("rs_head_b", out_addr, 7);
        check("rs_cnt1", fifo_count, 1);
        step();
        check("rs_empty", fifo_count, 0);

        // Asynchronous reset during ACK with two events queued
        apply_reset();
        req_in = 16'h0204;
        step();
        check("ar_ack2", ack_out, 16'h0004);
        auto_clr = 1'b0;
        step();
        step();
        check("ar_ack9", ack_out, 16'h0200);
        check("ar_cnt2", fifo_count, 2);
        #2;
        resetn = 1'b0;
        #1;
        check("ar_ack_clr", ack_out, 0);
        check("ar_spike_clr", out_spike, 0);
        check("ar_cnt_clr", fifo_count, 0);
        check("ar_events_clr", event_count, 0);
        @(posedge clk);
        #1;
        req_in   = 16'h1200;
        resetn   = 1'b1;
        auto_clr = 1'b1;
        step();
        check("ar_regrant", ack_out, 16'h0200);
        check("ar_regrant_addr", out_addr, 9);
        check("ar_regrant_events", event_count, 1);

        // Saturation
        apply_reset();
        out_ready = 1'b1;
        force dut.event_count = 16'hFFFE;
        #1;
        release dut.event_count;
        req_in = 16'h0007;
        step();
        check("sat_ack0", ack_out, 16'h0001);
        check("sat_first", event_count, 16'hFFFF);
        step();
        step();
        check("sat_second", event_count, 16'hFFFF);
        step();
        step();
        check("sat_ack2", ack_out, 16'h0004);
        check("sat_third", event_count, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hidden_spike_arbiter.md
# hidden_spike_arbiter

Address-event arbiter between the hidden layer and the output layer. It collects the sticky `spike_out` request lines of `N_NEURONS` hidden neurons and grants them in round-robin order with a one-cycle acknowledge pulse. Each granted neuron's address is queued in a small FIFO and presented to the output layer as a broadcast `out_spike`/`out_addr` pair. Events are never dropped: when the FIFO is full, requests stay pending in the neurons.

## Interface
Parameters:
- `N_NEURONS`, default 16: number of hidden request lines, 2..256.
- `IDX_W`, default 4: index width, equal to clog2(`N_NEURONS`).
- `ADDR_W`, default 8: width of `out_addr`.
- `ADDR_BASE`, default 0: offset added to the neuron index to form `out_addr`.
- `FIFO_DEPTH`, default 4: event queue depth, a power of two, 2..16.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `resetn` input, 1 bit: reset, asynchronous and active-low.
- `req_in` input, `N_NEURONS` bits: level requests, bit i = hidden neuron i `spike_out`.
- `ack_out` output, `N_NEURONS` bits: one-hot, one-cycle acknowledge; bit i drives neuron i `ack_in`.
- `out_ready` input, 1 bit: output layer accepts the head event this cycle.
- `out_spike` output, 1 bit: head event valid; drives output-layer `spike_in`.
- `out_addr` output, `ADDR_W` bits: head event address; drives output-layer `addr_in`.
- `fifo_count` output, clog2(`FIFO_DEPTH`)+1 bits: queued events.
- `event_count` output, 16 bits: total granted events, saturating at 16'hFFFF.

## Operation
- FSM with two states:
  - **IDLE**: grant decision made each cycle.
  - **ACK**: exactly one cycle long; then unconditionally back to IDLE.
- **Grant condition (IDLE)**: `req_in` is nonzero and `fifo_count < FIFO_DEPTH`.
  - Winner is the first set bit at an index ≥ `rr_ptr`, scanning upward with wrap.
  - On that edge:
    - `ack_out[winner] <= 1`.
    - Push `ADDR_BASE + winner`, truncated to `ADDR_W`, into the FIFO.
    - `rr_ptr <= (winner + 1) mod N_NEURONS`.
    - Increment `event_count` unless it is saturated.
    - State becomes ACK.
- **ACK state**:
  - `ack_out` holds the one-hot value; `req_in` is ignored.
  - The neuron clears its `spike_out` at the edge ending ACK, so IDLE always sees fresh requests.
- **Re-spike**: if a neuron spikes again during its ACK cycle, its request remains high (the neuron's spike has priority over ack). It is then arbitrated again as a new event; no special handling.
- **FIFO**: first-word-fall-through.
  - `out_spike = (fifo_count != 0)`, `out_addr` = head entry.
  - Pop happens when `out_spike && out_ready` at a clock edge.
- **Simultaneous push and pop**: count is unchanged and the head advances. A push into an empty FIFO with a simultaneous pop cannot occur, because pop requires a nonempty FIFO.
- **FIFO full**: no grant. Requests stay asserted in the neurons. `rr_ptr` and state hold.
- **Out-of-range requests**: bits of `req_in` ≥ `N_NEURONS` do not exist; any X on `req_in` in IDLE is a bench error.
- **Reset** (asynchronous, any time, including mid-ACK):
  - state = IDLE, `ack_out` = 0, `rr_ptr` = 0.
  - FIFO emptied: `fifo_count` = 0, `out_spike` = 0, `out_addr` = 0.
  - `event_count` = 0.
  - A pending ack is dropped; that neuron keeps its request and is re-granted after reset.

## Timing
- **Latency**: request seen at edge k (IDLE, space available) gives:
  - `ack_out` high in cycle k+1;
  - `out_spike` high in cycle k+1.
- **Throughput**: at most one grant every 2 cycles.
- **Ack pulse**: never wider than 1 cycle, and never two bits high at once.
- **Backpressure**:
  - With `out_ready` low, at most `FIFO_DEPTH` grants occur.
  - A pop at edge m frees space; a grant can occur at edge m+1 at the earliest if the FSM is in IDLE.
- **Registers**: all outputs are registered or decoded from registered state; there is no combinational path from `req_in` or `out_ready` to any output.

## Test plan
- **Single request**: release reset, `req_in[5]` held high until ack.
  - Expect `ack_out` = 16'h0020 for exactly 1 cycle.
  - Expect `out_spike` = 1 with `out_addr` = 8'd5 from the next cycle.
  - With `out_ready` = 1, `out_spike` drops after 1 cycle; `event_count` = 1.
- **Round-robin**: `req_in[0]`, `req_in[3]`, `req_in[15]` raised together; each line drops after its ack.
  - Expect grant order 0, 3, 15, with grants 2 cycles apart.
  - Repeat with `rr_ptr` = 4: expect order 15, 0, 3.
- **Backpressure**: `out_ready` = 0, all 16 requests high (`FIFO_DEPTH` = 4).
  - Expect exactly 4 acks (addresses 0..3), `fifo_count` = 4, then no further ack.
  - Raise `out_ready`: expect addresses 0..3 drained in order, then grants resume at 4.
- **Re-spike**: `req_in[7]` stays high through its ack cycle.
  - Expect a second grant of 7 two cycles after the first; FIFO holds 7, 7.
- **Reset mid-operation**: assert `resetn` = 0 asynchronously during an ACK cycle with 2 events queued.
  - Expect `ack_out`, `out_spike`, `fifo_count` and `event_count` to go to 0 immediately, without waiting for a clock edge.
  - After release, the still-high request is granted first from index 0.
- **Saturation**: preload `event_count` to 16'hFFFE via 65534 grants (or force), then 3 more grants.
  - Expect `event_count` = 16'hFFFF, held.
